// File: rtl/ex_hazard_ctrl_if.sv
// ID-to-EX hazard control bundle: decoded ID operand/destination info in,
// forwarding selects, stall/flush and stall statistics out.
interface ex_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_use_rs;
  logic                   id_use_rt;
  logic [4:0]             id_dest;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   ex_branch_taken;
  logic [1:0]             rsMux;
  logic [1:0]             rtMux;
  logic                   ex_valid;
  logic                   stall;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_regwrite, id_memread, ex_branch_taken,
    input  rsMux, rtMux, ex_valid, stall, flush, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_regwrite, id_memread, ex_branch_taken,
    output rsMux, rtMux, ex_valid, stall, flush, stall_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadow pipeline of in-flight destinations,
// registered forwarding selects, load-use stall and taken-branch flush.
module ex_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  ex_hazard_ctrl_if.slave     hz
);

  logic                   ex_valid_q;
  logic [4:0]             ex_dest_q;
  logic                   ex_regwrite_q;
  logic                   ex_memread_q;
  // WB producers never forward (regfile writes before read), so only
  // MEM's write-enable and destination are retained past EX.
  logic                   mem_wr_q;
  logic [4:0]             mem_dest_q;
  logic [1:0]             rs_sel_q;
  logic [1:0]             rt_sel_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic                   ex_wr;
  logic                   load_use;
  logic                   flush;
  logic                   stall;
  logic                   advance;
  logic [1:0]             rs_sel_d;
  logic [1:0]             rt_sel_d;

  assign ex_wr = ex_valid_q && ex_regwrite_q;

  always_comb begin
    load_use = 1'b0;
    if (hz.id_valid && ex_wr && ex_memread_q && (ex_dest_q != 5'd0)) begin
      load_use = (hz.id_use_rs && (ex_dest_q == hz.id_rs)) ||
                 (hz.id_use_rt && (ex_dest_q == hz.id_rt));
    end
  end

  assign flush   = hz.ex_branch_taken && ex_valid_q;
  assign stall   = load_use && !flush;
  assign advance = hz.id_valid && !stall && !flush;

  always_comb begin
    rs_sel_d = 2'b00;
    rt_sel_d = 2'b00;
    if (hz.id_use_rs && (hz.id_rs != 5'd0)) begin
      if (ex_wr && (ex_dest_q == hz.id_rs))
        rs_sel_d = 2'b01;
      else if (mem_wr_q && (mem_dest_q == hz.id_rs))
        rs_sel_d = 2'b10;
    end
    if (hz.id_use_rt && (hz.id_rt != 5'd0)) begin
      if (ex_wr && (ex_dest_q == hz.id_rt))
        rt_sel_d = 2'b01;
      else if (mem_wr_q && (mem_dest_q == hz.id_rt))
        rt_sel_d = 2'b10;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_dest_q     <= 5'd0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_dest_q    <= 5'd0;
      rs_sel_q      <= 2'b00;
      rt_sel_q      <= 2'b00;
    end else begin
      mem_wr_q   <= ex_wr;
      mem_dest_q <= ex_dest_q;
      if (advance) begin
        ex_valid_q    <= 1'b1;
        ex_dest_q     <= hz.id_dest;
        ex_regwrite_q <= hz.id_regwrite;
        ex_memread_q  <= hz.id_memread;
        rs_sel_q      <= rs_sel_d;
        rt_sel_q      <= rt_sel_d;
      end else begin
        ex_valid_q    <= 1'b0;
        ex_dest_q     <= 5'd0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
        rs_sel_q      <= 2'b00;
        rt_sel_q      <= 2'b00;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign hz.rsMux       = rs_sel_q;
  assign hz.rtMux       = rt_sel_q;
  assign hz.ex_valid    = ex_valid_q;
  assign hz.stall       = stall;
  assign hz.flush       = flush;
  assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding, load-use, $0, flush,
// async reset, and counter saturation on a 2-bit instance.
module tb_ex_hazard_ctrl;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  ex_hazard_ctrl_if #(.STALL_CNT_W(16)) hz_a ();
  ex_hazard_ctrl_if #(.STALL_CNT_W(2))  hz_b ();

  ex_hazard_ctrl #(.STALL_CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz_a.slave)
  );

  ex_hazard_ctrl #(.STALL_CNT_W(2)) dut_sat (
    .clock (clock),
    .reset (reset),
    .hz    (hz_b.slave)
  );

  // The 2-bit instance sees exactly the same ID stream as the main one.
  assign hz_b.id_valid        = hz_a.id_valid;
  assign hz_b.id_rs           = hz_a.id_rs;
  assign hz_b.id_rt           = hz_a.id_rt;
  assign hz_b.id_use_rs       = hz_a.id_use_rs;
  assign hz_b.id_use_rt       = hz_a.id_use_rt;
  assign hz_b.id_dest         = hz_a.id_dest;
  assign hz_b.id_regwrite     = hz_a.id_regwrite;
  assign hz_b.id_memread      = hz_a.id_memread;
  assign hz_b.ex_branch_taken = hz_a.ex_branch_taken;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr);
    hz_a.id_valid    = v;
    hz_a.id_rs       = rs;
    hz_a.id_rt       = rt;
    hz_a.id_use_rs   = urs;
    hz_a.id_use_rt   = urt;
    hz_a.id_dest     = dest;
    hz_a.id_regwrite = rw;
    hz_a.id_memread  = mr;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    hz_a.ex_branch_taken = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_rsMux", 32'(hz_a.rsMux), 0);
    check("rst_rtMux", 32'(hz_a.rtMux), 0);
    check("rst_ex_valid", 32'(hz_a.ex_valid), 0);
    check("rst_stall", 32'(hz_a.stall), 0);
    check("rst_flush", 32'(hz_a.flush), 0);
    check("rst_count", 32'(hz_a.stall_count), 0);
    reset = 1'b1;
    tick();

    // EX forwarding: add $3 <- $1,$2 ; sub $10 <- $3,$4
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    drive(1, 3, 4, 1, 1, 10, 1, 0);
    #1 check("exfwd_stall", 32'(hz_a.stall), 0);
    tick();
    check("exfwd_rsMux", 32'(hz_a.rsMux), 1);
    check("exfwd_rtMux", 32'(hz_a.rtMux), 0);
    check("exfwd_ex_valid", 32'(hz_a.ex_valid), 1);

    // MEM forwarding: add $3 ; or $7 <- $8,$9 ; reader $12 <- $1,$3
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    drive(1, 8, 9, 1, 1, 7, 1, 0);
    tick();
    drive(1, 1, 3, 1, 1, 12, 1, 0);
    tick();
    check("memfwd_rtMux", 32'(hz_a.rtMux), 2);
    check("memfwd_rsMux", 32'(hz_a.rsMux), 0);

    // Priority: $3 written in both EX and MEM, reader of $3 takes EX
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    drive(1, 3, 4, 1, 1, 13, 1, 0);
    tick();
    check("prio_rsMux", 32'(hz_a.rsMux), 1);
    check("prio_rtMux", 32'(hz_a.rtMux), 0);

    // Load-use: lw $5 <- ($1) ; add $11 <- $5,$6
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 6, 1, 1, 11, 1, 0);
    #1 check("lu_stall", 32'(hz_a.stall), 1);
    check("lu_flush", 32'(hz_a.flush), 0);
    tick();
    check("lu_bubble", 32'(hz_a.ex_valid), 0);
    check("lu_bubble_rs", 32'(hz_a.rsMux), 0);
    check("lu_count", 32'(hz_a.stall_count), 1);
    check("lu_stall_once", 32'(hz_a.stall), 0);
    tick();
    check("lu_rsMux", 32'(hz_a.rsMux), 2);
    check("lu_ex_valid", 32'(hz_a.ex_valid), 1);
    check("lu_count_hold", 32'(hz_a.stall_count), 1);

    // Register zero: add $0 ; lw $0 ; reader of $0 on both operands
    drive(1, 1, 2, 1, 1, 0, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 14, 1, 0);
    #1 check("r0_stall", 32'(hz_a.stall), 0);
    tick();
    check("r0_rsMux", 32'(hz_a.rsMux), 0);
    check("r0_rtMux", 32'(hz_a.rtMux), 0);
    check("r0_ex_valid", 32'(hz_a.ex_valid), 1);

    // Flush beats stall: lw $6 in EX resolves as taken branch, reader of $6 in ID
    drive(1, 1, 0, 1, 0, 6, 1, 1);
    tick();
    drive(1, 6, 0, 1, 0, 15, 1, 0);
    hz_a.ex_branch_taken = 1'b1;
    #1 check("fl_flush", 32'(hz_a.flush), 1);
    check("fl_stall", 32'(hz_a.stall), 0);
    tick();
    hz_a.ex_branch_taken = 1'b0;
    check("fl_bubble", 32'(hz_a.ex_valid), 0);
    check("fl_count", 32'(hz_a.stall_count), 1);

    // Four more load-use stalls: total five
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, 0, 5, 1, 1);
      tick();
      drive(1, 5, 6, 1, 1, 11, 1, 0);
      #1 check("rep_stall", 32'(hz_a.stall), 1);
      tick();
      check("rep_count", 32'(hz_a.stall_count), 32'(2 + i));
      tick();
      check("rep_rsMux", 32'(hz_a.rsMux), 2);
    end
    check("sat_count", 32'(hz_b.stall_count), 3);

    // Async reset during a stall
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 6, 1, 1, 11, 1, 0);
    #1 check("mr_stall_pre", 32'(hz_a.stall), 1);
    check("mr_ex_valid_pre", 32'(hz_a.ex_valid), 1);
    #1 reset = 1'b0;
    #1;
    check("mr_stall", 32'(hz_a.stall), 0);
    check("mr_flush", 32'(hz_a.flush), 0);
    check("mr_ex_valid", 32'(hz_a.ex_valid), 0);
    check("mr_rsMux", 32'(hz_a.rsMux), 0);
    check("mr_count", 32'(hz_a.stall_count), 0);
    check("mr_sat_count", 32'(hz_b.stall_count), 0);
    tick();
    reset = 1'b1;
    #1 check("post_rst_stall", 32'(hz_a.stall), 0);
    tick();
    check("post_rst_ex_valid", 32'(hz_a.ex_valid), 1);
    check("post_rst_rsMux", 32'(hz_a.rsMux), 0);
    check("post_rst_count", 32'(hz_a.stall_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the EX stage. It tracks destination registers of in-flight instructions in EX, MEM and WB, and generates the registered forwarding selects `rsMux`/`rtMux` consumed by the EX operand muxes. It also detects load-use hazards (stall plus bubble) and taken-branch flushes, and keeps a saturating stall counter. It sits between the ID stage decode and the EX/MEM/WB pipeline registers.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall counter.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_rs`, `id_rt` input 5: source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt` input 1: the ID instruction actually reads rs / rt.
- `id_dest` input 5: destination register of the ID instruction.
- `id_regwrite` input 1: the ID instruction writes `id_dest`.
- `id_memread` input 1: the ID instruction is a load.
- `ex_branch_taken` input 1: the branch currently in EX resolved taken.
- `rsMux`, `rtMux` output 2: forwarding selects for the instruction in EX.
  - 00 = register file data.
  - 01 = EX/MEM result.
  - 10 = MEM/WB result.
  - 11 never driven.
- `ex_valid` output 1: the instruction in EX is real, not a bubble.
- `stall` output 1: hold PC and IF/ID this cycle.
- `flush` output 1: squash IF/ID and the ID instruction.
- `stall_count` output `STALL_CNT_W`: number of load-use stall cycles, saturating.

## Operation
- Shadow pipeline: three stages EX, MEM and WB, each holding {valid, dest, regwrite, memread}. All three advance every cycle. There is no external enable.
- Advance into EX:
  - If `stall` or `flush` is 1, or `id_valid` is 0, EX receives a bubble (valid=0, regwrite=0, memread=0).
  - Otherwise EX receives the ID fields.
  - MEM always takes the old EX contents; WB always takes the old MEM contents.
- Forwarding selects are computed from ID fields and registered at the same edge the instruction enters EX. For rs (rt is identical, using `id_rt`/`id_use_rt`):
  - 01 if `id_use_rs`, `id_rs`≠0, and the current EX stage is valid with regwrite=1 and dest=`id_rs`.
  - Else 10 if the same conditions hold against the current MEM stage.
  - Else 00.
  - The closest producer wins.
- Register 0 never forwards.
- A WB-stage producer needs no forwarding: the register file writes before it reads.
- A bubble entering EX loads `rsMux`/`rtMux` = 00.
- Load-use hazard. `stall` = 1 when all of the following hold:
  - `id_valid` = 1.
  - The EX stage is valid with memread=1 and regwrite=1.
  - Its dest is nonzero and equals `id_rs` (with `id_use_rs`) or `id_rt` (with `id_use_rt`).
- After one stall cycle the load sits in MEM and a bubble sits in EX. The held ID instruction then enters EX with select 10, so each load-use stall lasts exactly one cycle.
- Branch flush: `flush` = `ex_branch_taken` AND the EX stage is valid.
- Flush and stall in the same cycle: flush wins and `stall` is forced to 0.
- `stall_count` increments on every cycle with `stall`=1 and saturates at all-ones.
- `ex_valid` equals the EX-stage valid bit.

## Timing
- `stall` and `flush` are combinational from the ID inputs and the shadow registers, valid in the same cycle.
- `rsMux`, `rtMux` and `ex_valid` are registered: one cycle of latency from ID to EX.
- Reset (asynchronous, `reset`=0):
  - All shadow stages invalid.
  - `rsMux`=`rtMux`=00, `ex_valid`=0, `stall_count`=0.
  - Hence `stall`=0 and `flush`=0 while in reset.
- Reset asserted mid-stall clears everything immediately. The first cycle after release is a normal cycle.
- No back-to-back stall arises from a single load. Two consecutive loads feeding each other produce one stall each.

## Test plan
- **EX forwarding:** `add $3` followed by `sub` reading `$3` as rs → at the next edge `rsMux`=01, `rtMux`=00, `stall`=0.
- **MEM forwarding and priority:**
  - `add $3`, an independent instruction, then a reader of `$3` as rt → `rtMux`=10.
  - Writers of `$3` in both EX and MEM → `rsMux`=01.
- **Load-use:** `lw $5` followed by `add` reading `$5`:
  - `stall`=1 for exactly one cycle, then `ex_valid`=0 (bubble).
  - Next edge: `rsMux`=10, `ex_valid`=1.
  - `stall_count` goes 0→1.
- **Register zero:** producer writing `$0`, consumer reading `$0` → selects stay 00 and no stall, even when the producer is a load.
- **Flush with stall:** taken branch in EX together with a load-use condition in ID → `flush`=1, `stall`=0, next EX is a bubble, `stall_count` unchanged.
- **Reset and saturation:**
  - Assert `reset` low during a stall → all outputs 0 asynchronously.
  - With `STALL_CNT_W`=2, five stalls → `stall_count`=3.
